// File: rtl/commit_trace_fifo_pkg.sv
// Shared trace-entry layout and default sizing for the commit trace FIFO.
// Processor-side and harness-side code both import this package.
package commit_trace_fifo_pkg;

  localparam int DEF_DEPTH  = 16;
  localparam int DEF_CYC_W  = 16;
  localparam int DEF_DROP_W = 8;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int ENTRY_W = DEF_CYC_W + 37;

  typedef struct packed {
    logic [DEF_CYC_W-1:0] cycle;
    logic [4:0]           rd;
    logic [31:0]          data;
  } trace_entry_t;

  function automatic int entry_w(input int cyc_w);
    return cyc_w + 37;
  endfunction

endpackage

// File: rtl/commit_trace_fifo_if.sv
// Write-port snoop inputs and trace drain outputs of the commit monitor.
// master = processor/harness side, slave = the monitor.
interface commit_trace_fifo_if
  import commit_trace_fifo_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CYC_W  = DEF_CYC_W,
  parameter int DROP_W = DEF_DROP_W
);

  logic                     capture_en;
  logic                     ctrl_writeEnable;
  logic [4:0]               ctrl_writeReg;
  logic [31:0]              data_writeReg;
  logic                     out_ready;
  logic                     out_valid;
  logic [CYC_W-1:0]         out_cycle;
  logic [4:0]               out_rd;
  logic [31:0]              out_data;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;
  logic [DROP_W-1:0]        dropped;

  modport master (
    output capture_en,
    output ctrl_writeEnable,
    output ctrl_writeReg,
    output data_writeReg,
    output out_ready,
    input  out_valid,
    input  out_cycle,
    input  out_rd,
    input  out_data,
    input  count,
    input  overflow,
    input  dropped
  );

  modport slave (
    input  capture_en,
    input  ctrl_writeEnable,
    input  ctrl_writeReg,
    input  data_writeReg,
    input  out_ready,
    output out_valid,
    output out_cycle,
    output out_rd,
    output out_data,
    output count,
    output overflow,
    output dropped
  );

endinterface

// File: rtl/sync_fifo_fwft.sv
// Generic synchronous first-word-fall-through FIFO with explicit occupancy.
// Push when full is accepted only if a pop happens on the same edge.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign valid   = (cnt != '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);
  assign count   = cnt;
  assign dout    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case (1'b1)
        (do_push && !do_pop): cnt <= cnt + (AW+1)'(1);
        (do_pop && !do_push): cnt <= cnt - (AW+1)'(1);
        default:              cnt <= cnt;
      endcase
    end
  end

  // Storage carries no reset; emptiness is tracked by cnt alone.
  always_ff @(posedge clock) begin
    if (do_push && !reset) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/commit_trace_fifo.sv
// Commit monitor: timestamps register-file writes to r1..r31 and buffers
// them in a FWFT FIFO, with sticky overflow and saturating drop count.
module commit_trace_fifo
  import commit_trace_fifo_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CYC_W  = DEF_CYC_W,
  parameter int DROP_W = DEF_DROP_W
) (
  input  logic                 clock,
  input  logic                 reset,
  commit_trace_fifo_if.slave   bus
);

  localparam int EW = entry_w(CYC_W);

  logic [CYC_W-1:0]  cyc_q;
  logic              push_req;
  logic              full;
  logic              drop;
  logic              ovf_q;
  logic [DROP_W-1:0] drop_q;
  logic [EW-1:0]     din;
  logic [EW-1:0]     dout;

  assign push_req = bus.capture_en && bus.ctrl_writeEnable
                 && (bus.ctrl_writeReg != REG_ZERO);

  // A full FIFO still accepts the push when the head leaves on this edge.
  assign drop = push_req && full && !(bus.out_valid && bus.out_ready);

  assign din = {cyc_q, bus.ctrl_writeReg, bus.data_writeReg};
  assign {bus.out_cycle, bus.out_rd, bus.out_data} = dout;
  assign bus.overflow = ovf_q;
  assign bus.dropped  = drop_q;

  always_ff @(posedge clock) begin
    if (reset) cyc_q <= '0;
    else       cyc_q <= cyc_q + CYC_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else if (drop) begin
      ovf_q <= 1'b1;
      if (drop_q != '1) drop_q <= drop_q + DROP_W'(1);
    end
  end

  sync_fifo_fwft #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_req),
    .pop   (bus.out_ready),
    .din   (din),
    .dout  (dout),
    .valid (bus.out_valid),
    .full  (full),
    .count (bus.count)
  );

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Scoreboard bench for commit_trace_fifo: queue-based reference model,
// negedge monitor, directed scenarios followed by random traffic.
module tb_commit_trace_fifo;
  import commit_trace_fifo_pkg::*;

  localparam int DEPTH  = DEF_DEPTH;
  localparam int CYC_W  = DEF_CYC_W;
  localparam int DROP_W = DEF_DROP_W;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  logic clock;
  logic reset;

  commit_trace_fifo_if #(.DEPTH(DEPTH), .CYC_W(CYC_W), .DROP_W(DROP_W)) bus ();

  commit_trace_fifo #(.DEPTH(DEPTH), .CYC_W(CYC_W), .DROP_W(DROP_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  trace_entry_t exp_q[$];
  int unsigned  m_cyc   = 0;
  bit           m_ovf   = 0;
  int           m_drop  = 0;
  bit           started = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: occupancy is just the queue length.
  task automatic model_step();
    trace_entry_t e;
    bit popped;
    if (reset) begin
      exp_q.delete();
      m_cyc   = 0;
      m_ovf   = 0;
      m_drop  = 0;
      started = 1;
      return;
    end
    popped = (exp_q.size() != 0) && (bus.out_ready === 1'b1);
    if (popped) void'(exp_q.pop_front());
    if (bus.capture_en && bus.ctrl_writeEnable && bus.ctrl_writeReg != 5'd0) begin
      if (exp_q.size() < DEPTH) begin
        e.cycle = m_cyc[CYC_W-1:0];
        e.rd    = bus.ctrl_writeReg;
        e.data  = bus.data_writeReg;
        exp_q.push_back(e);
      end else begin
        m_ovf = 1;
        if (m_drop < DROP_MAX) m_drop++;
      end
    end
    m_cyc = (m_cyc + 1) % (1 << CYC_W);
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  initial forever begin
    @(negedge clock);
    if (started) begin
      chk("valid", bus.out_valid, exp_q.size() != 0);
      chk("count", bus.count, exp_q.size());
      chk("overflow", bus.overflow, m_ovf);
      chk("dropped", bus.dropped, m_drop);
      if (exp_q.size() != 0) begin
        chk("head_cycle", bus.out_cycle, exp_q[0].cycle);
        chk("head_rd", bus.out_rd, exp_q[0].rd);
        chk("head_data", bus.out_data, exp_q[0].data);
      end else begin
        chk("empty_cycle", bus.out_cycle, 0);
        chk("empty_rd", bus.out_rd, 0);
        chk("empty_data", bus.out_data, 0);
      end
    end
  end

  task automatic drive(input logic ce, input logic we, input logic [4:0] rd,
                       input logic [31:0] d, input logic rdy);
    bus.capture_en       = ce;
    bus.ctrl_writeEnable = we;
    bus.ctrl_writeReg    = rd;
    bus.data_writeReg    = d;
    bus.out_ready        = rdy;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.capture_en       = 1'b0;
    bus.ctrl_writeEnable = 1'b0;
    bus.ctrl_writeReg    = '0;
    bus.data_writeReg    = '0;
    bus.out_ready        = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_count", bus.count, 0);
    reset = 1'b0;

    // r5=42 on the edge stamped 3
    repeat (3) drive(1, 0, 0, 0, 0);
    drive(1, 1, 5, 42, 0);
    chk("t1_valid", bus.out_valid, 1);
    chk("t1_cycle", bus.out_cycle, 3);
    chk("t1_rd", bus.out_rd, 5);
    chk("t1_data", bus.out_data, 42);
    chk("t1_count", bus.count, 1);
    drive(0, 0, 0, 0, 1);

    // r0 write and capture disabled
    drive(1, 1, 0, 7, 0);
    drive(0, 1, 9, 1, 0);
    chk("t2_count", bus.count, 0);
    chk("t2_valid", bus.out_valid, 0);

    // overflow by two
    for (int i = 1; i <= 18; i++) drive(1, 1, 5'(i), 32'(i * 3), 0);
    chk("t3_count", bus.count, 16);
    chk("t3_ovf", bus.overflow, 1);
    chk("t3_drop", bus.dropped, 2);
    repeat (16) drive(0, 0, 0, 0, 1);
    chk("t3_drained", bus.count, 0);
    drive(1, 0, 0, 0, 1);

    // full with simultaneous push and pop
    for (int i = 1; i <= 16; i++) drive(1, 1, 5'(i), 32'(i + 100), 0);
    drive(1, 1, 20, 99, 1);
    chk("t4_count", bus.count, 16);
    chk("t4_drop", bus.dropped, 2);
    repeat (15) drive(0, 0, 0, 0, 1);
    chk("t4_last_rd", bus.out_rd, 20);
    chk("t4_last_data", bus.out_data, 99);
    drive(0, 0, 0, 0, 1);

    // timestamp wrap
    repeat ((1 << CYC_W) + 5) drive(0, 0, 0, 0, 0);
    drive(1, 1, 3, 1, 0);
    chk("t5_rd", bus.out_rd, 3);
    chk("t5_cycle", bus.out_cycle, (m_cyc + (1 << CYC_W) - 1) % (1 << CYC_W));
    drive(0, 0, 0, 0, 1);

    // reset with ten entries and a pending push
    for (int i = 1; i <= 10; i++) drive(1, 1, 5'(i), $urandom, 0);
    chk("t6_pre", bus.count, 10);
    reset = 1'b1;
    drive(1, 1, 7, 5, 1);
    reset = 1'b0;
    chk("t6_count", bus.count, 0);
    chk("t6_valid", bus.out_valid, 0);
    chk("t6_ovf", bus.overflow, 0);
    chk("t6_drop", bus.dropped, 0);

    // random traffic: slow then fast consumer
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), $urandom,
            (i < 1500) ? ($urandom_range(0, 3) == 0)
                       : ($urandom_range(0, 3) != 0));
    end
    repeat (20) drive(0, 0, 0, 0, 1);
    @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
